jtframe_uart_bridge: RTL and testbench

Byte-level command responder on the host-facing end of the UART link. It consumes received bytes from the UART core (`rx_data`/`rx_done`/`rx_error`), decodes read/write commands from a PC-side debugger, executes them as single-byte accesses on a generic memory bus, and returns a one-byte reply through the UART transmit interface (`tx_data`/`tx_wr`/`tx_done`). It sits between the UART core and a debug-accessible RAM/register space in the core.

---
 rtl/jtframe_uart_bridge.sv | 98 +++++++++
 tb/tb_jtframe_uart_bridge.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jtframe_uart_bridge.sv
// jtframe_uart_bridge: UART command responder running single-byte debug reads/writes on a memory bus
//   clk, rst_n, cen              clock, asynchronous active-low reset, clock enable shared with the UART core
//   rx_data, rx_done, rx_error   received byte stream; rx_error flags a framing error with rx_done
//   tx_data, tx_wr, tx_done      one-byte reply to the UART transmitter
//   bus_addr, bus_dout, bus_wr, bus_rd, bus_din, bus_ack   request held until bus_ack or BUS_WAIT expiry
//   busy                         high whenever a command is in progress
module jtframe_uart_bridge #(
  parameter int          AW       = 16,
  parameter logic [15:0] TIMEOUT  = 16'd50000,
  parameter logic [7:0]  BUS_WAIT = 8'd255
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cen,
  input  logic [7:0]    rx_data,
  input  logic          rx_done,
  input  logic          rx_error,
  output logic [7:0]    tx_data,
  output logic          tx_wr,
  input  logic          tx_done,
  output logic [AW-1:0] bus_addr,
  output logic [7:0]    bus_dout,
  output logic          bus_wr,
  output logic          bus_rd,
  input  logic [7:0]    bus_din,
  input  logic          bus_ack,
  output logic          busy
);
  typedef enum logic [2:0] {IDLE, ADDR_H, ADDR_L, DATA, BUS, SEND, WAIT_TX} state_t;
  state_t      st;
  logic        is_wr;
  logic [7:0]  addr_h, reply, wcnt;
  logic [15:0] tmo, addr;
  logic        tmo_hit;
  assign addr    = {addr_h, rx_data};
  assign tmo_hit = tmo == TIMEOUT - 16'd1;
  assign busy    = st != IDLE;
  // tmo restarts on any rx_done; it is only acted on in the receive states, which are
  // always entered through an accepted byte. Error replies are preloaded on every byte
  // because the bus path overwrites reply before SEND.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      st       <= IDLE;
      is_wr    <= 1'b0;
      addr_h   <= '0;
      reply    <= '0;
      wcnt     <= '0;
      tmo      <= '0;
      tx_data  <= '0;
      tx_wr    <= 1'b0;
      bus_addr <= '0;
      bus_dout <= '0;
      bus_wr   <= 1'b0;
      bus_rd   <= 1'b0;
    end else if (cen) begin
      tx_wr <= 1'b0;
      tmo   <= rx_done ? 16'd0 : tmo + 16'd1;
      wcnt  <= st == BUS ? wcnt + 8'd1 : 8'd0;
      case (st)
        IDLE: if (rx_done) begin
          is_wr <= rx_data == 8'h57;
          reply <= rx_error ? 8'h45 : 8'h3F;
          st    <= !rx_error && (rx_data == 8'h52 || rx_data == 8'h57) ? ADDR_H : SEND;
        end
        ADDR_H: if (rx_done) begin
          addr_h <= rx_data;
          reply  <= 8'h45;
          st     <= rx_error ? SEND : ADDR_L;
        end else if (tmo_hit) st <= IDLE;
        ADDR_L: if (rx_done) begin
          bus_addr <= addr[AW-1:0];
          reply    <= 8'h45;
          bus_rd   <= !rx_error && !is_wr;
          st       <= rx_error ? SEND : is_wr ? DATA : BUS;
        end else if (tmo_hit) st <= IDLE;
        DATA: if (rx_done) begin
          bus_dout <= rx_data;
          reply    <= 8'h45;
          bus_wr   <= !rx_error;
          st       <= rx_error ? SEND : BUS;
        end else if (tmo_hit) st <= IDLE;
        // an ack in the final wait cycle wins over the timeout
        BUS: if (bus_ack || wcnt == BUS_WAIT - 8'd1) begin
          reply  <= bus_ack ? (is_wr ? 8'h4B : bus_din) : 8'h54;
          bus_rd <= 1'b0;
          bus_wr <= 1'b0;
          st     <= SEND;
        end
        SEND: begin
          tx_data <= reply;
          tx_wr   <= 1'b1;
          st      <= WAIT_TX;
        end
        WAIT_TX: if (tx_done) st <= IDLE;
        default: st <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_jtframe_uart_bridge.sv
// tb_jtframe_uart_bridge: scoreboard bench for the UART command bridge
module tb_jtframe_uart_bridge;
  localparam logic [15:0] TMO = 16'd300;
  localparam logic [7:0]  BW  = 8'd255;
  logic        clk = 1'b0, rst_n = 1'b0, cen = 1'b1;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_done = 1'b0, rx_error = 1'b0, tx_done = 1'b0;
  logic [7:0]  tx_data, bus_dout;
  logic        tx_wr, bus_wr, bus_rd, busy;
  logic [15:0] bus_addr;
  logic [7:0]  bus_din = 8'h00;
  logic        bus_ack = 1'b0;
  int passed = 0, total = 0;
  int tx_cnt = 0, rd_cnt = 0, wr_cnt = 0, both_cnt = 0, addr_chg = 0;
  logic        prev_rd = 1'b0, prev_wr = 1'b0;
  logic [15:0] prev_addr = 16'h0;
  logic [7:0]  exp_q[$];

  always #5 clk = ~clk;

  jtframe_uart_bridge #(.AW(16), .TIMEOUT(TMO), .BUS_WAIT(BW)) dut (
    .clk(clk), .rst_n(rst_n), .cen(cen),
    .rx_data(rx_data), .rx_done(rx_done), .rx_error(rx_error),
    .tx_data(tx_data), .tx_wr(tx_wr), .tx_done(tx_done),
    .bus_addr(bus_addr), .bus_dout(bus_dout), .bus_wr(bus_wr), .bus_rd(bus_rd),
    .bus_din(bus_din), .bus_ack(bus_ack), .busy(busy)
  );

  always @(negedge clk) begin
    if (tx_wr === 1'b1) tx_cnt++;
    if (bus_rd === 1'b1 && !prev_rd) rd_cnt++;
    if (bus_wr === 1'b1 && !prev_wr) wr_cnt++;
    if (bus_rd === 1'b1 && bus_wr === 1'b1) both_cnt++;
    if ((bus_rd || bus_wr) && (prev_rd || prev_wr) && bus_addr !== prev_addr) addr_chg++;
    prev_rd = bus_rd === 1'b1;
    prev_wr = bus_wr === 1'b1;
    prev_addr = bus_addr;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached with %0d/%0d checks passed", passed, total);
    $fatal(1);
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic err = 1'b0);
    rx_data = b;
    rx_done = 1'b1;
    rx_error = err;
    tick();
    rx_done = 1'b0;
    rx_error = 1'b0;
  endtask

  task automatic wait_tx(output int lat, output logic [7:0] d);
    lat = 0;
    d = 8'hxx;
    for (int i = 0; i < 50; i++) begin
      tick();
      lat++;
      if (tx_wr === 1'b1) begin
        d = tx_data;
        break;
      end
    end
  endtask

  task automatic finish_tx;
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    tick(2);
    total++; if (tx_wr !== 1'b0) $display("FAIL reset_tx_wr: got %b expected 0", tx_wr); else passed++;
    total++; if (tx_data !== 8'h00) $display("FAIL reset_tx_data: got %h expected 00", tx_data); else passed++;
    total++; if (bus_addr !== 16'h0) $display("FAIL reset_bus_addr: got %h expected 0000", bus_addr); else passed++;
    total++; if (bus_dout !== 8'h00) $display("FAIL reset_bus_dout: got %h expected 00", bus_dout); else passed++;
    total++; if (bus_wr !== 1'b0 || bus_rd !== 1'b0) $display("FAIL reset_bus_req: got wr=%b rd=%b expected 0 0", bus_wr, bus_rd); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else passed++;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_write;
    int lat, w0, r0;
    logic [7:0] d, e;
    w0 = wr_cnt;
    r0 = rd_cnt;
    send_byte(8'h57);
    total++; if (busy !== 1'b1) $display("FAIL write_busy_cmd: got %b expected 1", busy); else passed++;
    send_byte(8'h12);
    send_byte(8'h34);
    total++; if (bus_wr !== 1'b0) $display("FAIL write_early_req: got %b expected 0", bus_wr); else passed++;
    exp_q.push_back(8'h4B);
    send_byte(8'hA5);
    total++; if (bus_wr !== 1'b1 || bus_rd !== 1'b0) $display("FAIL write_req: got wr=%b rd=%b expected 1 0", bus_wr, bus_rd); else passed++;
    total++; if (bus_addr !== 16'h1234) $display("FAIL write_addr: got %h expected 1234", bus_addr); else passed++;
    total++; if (bus_dout !== 8'hA5) $display("FAIL write_dout: got %h expected a5", bus_dout); else passed++;
    tick(2);
    total++; if (bus_wr !== 1'b1) $display("FAIL write_hold: got %b expected 1", bus_wr); else passed++;
    bus_ack = 1'b1;
    tick();
    bus_ack = 1'b0;
    total++; if (bus_wr !== 1'b0) $display("FAIL write_drop: got %b expected 0", bus_wr); else passed++;
    wait_tx(lat, d);
    e = exp_q.pop_front();
    total++; if (d !== e) $display("FAIL write_reply: got %h expected %h", d, e); else passed++;
    total++; if (lat !== 1) $display("FAIL write_latency: got %0d expected 1", lat); else passed++;
    tick();
    total++; if (tx_wr !== 1'b0) $display("FAIL write_strobe_len: got %b expected 0", tx_wr); else passed++;
    total++; if (tx_data !== 8'h4B) $display("FAIL write_tx_hold: got %h expected 4b", tx_data); else passed++;
    total++; if (busy !== 1'b1) $display("FAIL write_busy_wait: got %b expected 1", busy); else passed++;
    finish_tx();
    total++; if (busy !== 1'b0) $display("FAIL write_busy_end: got %b expected 0", busy); else passed++;
    total++; if (wr_cnt - w0 !== 1 || rd_cnt !== r0) $display("FAIL write_pulses: got wr=%0d rd=%0d expected 1 0", wr_cnt - w0, rd_cnt - r0); else passed++;
  endtask

  task automatic test_read;
    int lat, w0, r0, a0;
    logic [7:0] d, e;
    w0 = wr_cnt;
    r0 = rd_cnt;
    a0 = addr_chg;
    bus_din = 8'h3C;
    send_byte(8'h52);
    send_byte(8'h00);
    exp_q.push_back(8'h3C);
    send_byte(8'h10);
    total++; if (bus_rd !== 1'b1 || bus_wr !== 1'b0) $display("FAIL read_req: got rd=%b wr=%b expected 1 0", bus_rd, bus_wr); else passed++;
    total++; if (bus_addr !== 16'h0010) $display("FAIL read_addr: got %h expected 0010", bus_addr); else passed++;
    tick(3);
    bus_ack = 1'b1;
    tick();
    bus_ack = 1'b0;
    bus_din = 8'h00;
    total++; if (bus_rd !== 1'b0) $display("FAIL read_drop: got %b expected 0", bus_rd); else passed++;
    wait_tx(lat, d);
    e = exp_q.pop_front();
    total++; if (d !== e) $display("FAIL read_reply: got %h expected %h", d, e); else passed++;
    total++; if (rd_cnt - r0 !== 1 || wr_cnt !== w0) $display("FAIL read_pulses: got rd=%0d wr=%0d expected 1 0", rd_cnt - r0, wr_cnt - w0); else passed++;
    total++; if (addr_chg !== a0 || both_cnt !== 0) $display("FAIL read_stable: got addr_changes=%0d overlaps=%0d expected 0 0", addr_chg - a0, both_cnt); else passed++;
    finish_tx();
  endtask

  task automatic test_unknown_error;
    int lat, w0, r0;
    logic [7:0] d, e;
    w0 = wr_cnt;
    r0 = rd_cnt;
    exp_q.push_back(8'h3F);
    send_byte(8'h00);
    wait_tx(lat, d);
    e = exp_q.pop_front();
    total++; if (d !== e) $display("FAIL unknown_reply: got %h expected %h", d, e); else passed++;
    total++; if (lat !== 1) $display("FAIL unknown_latency: got %0d expected 1", lat); else passed++;
    finish_tx();
    total++; if (busy !== 1'b0) $display("FAIL unknown_busy_end: got %b expected 0", busy); else passed++;
    send_byte(8'h57);
    exp_q.push_back(8'h45);
    send_byte(8'h12, 1'b1);
    wait_tx(lat, d);
    e = exp_q.pop_front();
    total++; if (d !== e) $display("FAIL error_reply: got %h expected %h", d, e); else passed++;
    total++; if (lat !== 1) $display("FAIL error_latency: got %0d expected 1", lat); else passed++;
    finish_tx();
    total++; if (busy !== 1'b0) $display("FAIL error_busy_end: got %b expected 0", busy); else passed++;
    total++; if (wr_cnt !== w0 || rd_cnt !== r0) $display("FAIL unknown_no_bus: got wr=%0d rd=%0d expected 0 0", wr_cnt - w0, rd_cnt - r0); else passed++;
  endtask

  task automatic test_inter_timeout;
    int lat, t0;
    logic [7:0] d, e;
    t0 = tx_cnt;
    send_byte(8'h52);
    send_byte(8'h12);
    tick(int'(TMO) - 1);
    total++; if (busy !== 1'b1) $display("FAIL ito_before: got %b expected 1", busy); else passed++;
    tick(6);
    total++; if (busy !== 1'b0) $display("FAIL ito_idle: got %b expected 0", busy); else passed++;
    total++; if (tx_cnt !== t0) $display("FAIL ito_silent: got %0d replies expected 0", tx_cnt - t0); else passed++;
    bus_din = 8'h77;
    send_byte(8'h52);
    send_byte(8'h00);
    exp_q.push_back(8'h77);
    send_byte(8'h00);
    total++; if (bus_rd !== 1'b1 || bus_addr !== 16'h0000) $display("FAIL ito_next_req: got rd=%b addr=%h expected 1 0000", bus_rd, bus_addr); else passed++;
    bus_ack = 1'b1;
    tick();
    bus_ack = 1'b0;
    wait_tx(lat, d);
    e = exp_q.pop_front();
    total++; if (d !== e) $display("FAIL ito_next_reply: got %h expected %h", d, e); else passed++;
    finish_tx();
  endtask

  task automatic test_bus_timeout;
    int lat, n, t0;
    logic [7:0] d, e;
    exp_q.push_back(8'h54);
    send_byte(8'h52);
    send_byte(8'h00);
    send_byte(8'h01);
    n = 0;
    while (bus_rd === 1'b1 && n < 1000) begin
      n++;
      tick();
    end
    total++; if (n !== int'(BW)) $display("FAIL bto_req_cycles: got %0d expected %0d", n, BW); else passed++;
    wait_tx(lat, d);
    e = exp_q.pop_front();
    total++; if (d !== e) $display("FAIL bto_reply: got %h expected %h", d, e); else passed++;
    total++; if (lat !== 1) $display("FAIL bto_latency: got %0d expected 1", lat); else passed++;
    t0 = tx_cnt;
    send_byte(8'h52);
    send_byte(8'h57);
    send_byte(8'h00, 1'b1);
    total++; if (busy !== 1'b1 || bus_rd !== 1'b0) $display("FAIL bto_inject_wait: got busy=%b rd=%b expected 1 0", busy, bus_rd); else passed++;
    finish_tx();
    tick(5);
    total++; if (busy !== 1'b0 || tx_cnt !== t0) $display("FAIL bto_inject_ignored: got busy=%b replies=%0d expected 0 0", busy, tx_cnt - t0); else passed++;
    bus_din = 8'h99;
    exp_q.push_back(8'h99);
    send_byte(8'h52);
    send_byte(8'h00);
    send_byte(8'h02);
    tick(int'(BW) - 1);
    total++; if (bus_rd !== 1'b1) $display("FAIL bto_last_cycle: got %b expected 1", bus_rd); else passed++;
    bus_ack = 1'b1;
    tick();
    bus_ack = 1'b0;
    wait_tx(lat, d);
    e = exp_q.pop_front();
    total++; if (d !== e) $display("FAIL bto_ack_priority: got %h expected %h", d, e); else passed++;
    finish_tx();
  endtask

  task automatic test_cen;
    int lat;
    logic [7:0] d, e;
    cen = 1'b0;
    rx_data = 8'h00;
    rx_done = 1'b1;
    tick(4);
    rx_done = 1'b0;
    total++; if (busy !== 1'b0) $display("FAIL cen_rx_ignored: got %b expected 0", busy); else passed++;
    cen = 1'b1;
    send_byte(8'h52);
    send_byte(8'h00);
    exp_q.push_back(8'h55);
    send_byte(8'h03);
    cen = 1'b0;
    bus_din = 8'hAA;
    bus_ack = 1'b1;
    tick(3);
    bus_ack = 1'b0;
    cen = 1'b1;
    tick(2);
    total++; if (bus_rd !== 1'b1) $display("FAIL cen_ack_ignored: got %b expected 1", bus_rd); else passed++;
    bus_din = 8'h55;
    bus_ack = 1'b1;
    tick();
    bus_ack = 1'b0;
    wait_tx(lat, d);
    e = exp_q.pop_front();
    total++; if (d !== e) $display("FAIL cen_reply: got %h expected %h", d, e); else passed++;
    finish_tx();
  endtask

  task automatic test_async_reset;
    int lat;
    logic [7:0] d, e;
    send_byte(8'h57);
    send_byte(8'h00);
    send_byte(8'h20);
    send_byte(8'h5A);
    total++; if (bus_wr !== 1'b1) $display("FAIL areset_pre_req: got %b expected 1", bus_wr); else passed++;
    #2 rst_n = 1'b0;
    #1;
    total++; if (bus_wr !== 1'b0 || bus_rd !== 1'b0) $display("FAIL areset_req: got wr=%b rd=%b expected 0 0", bus_wr, bus_rd); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL areset_busy: got %b expected 0", busy); else passed++;
    total++; if (bus_addr !== 16'h0 || bus_dout !== 8'h00) $display("FAIL areset_bus: got addr=%h dout=%h expected 0000 00", bus_addr, bus_dout); else passed++;
    total++; if (tx_data !== 8'h00 || tx_wr !== 1'b0) $display("FAIL areset_tx: got data=%h wr=%b expected 00 0", tx_data, tx_wr); else passed++;
    tick();
    rst_n = 1'b1;
    tick();
    bus_din = 8'h11;
    send_byte(8'h52);
    send_byte(8'h00);
    exp_q.push_back(8'h11);
    send_byte(8'h20);
    total++; if (bus_rd !== 1'b1 || bus_addr !== 16'h0020) $display("FAIL areset_next_req: got rd=%b addr=%h expected 1 0020", bus_rd, bus_addr); else passed++;
    bus_ack = 1'b1;
    tick();
    bus_ack = 1'b0;
    wait_tx(lat, d);
    e = exp_q.pop_front();
    total++; if (d !== e) $display("FAIL areset_next_reply: got %h expected %h", d, e); else passed++;
    finish_tx();
    total++; if (busy !== 1'b0) $display("FAIL areset_busy_end: got %b expected 0", busy); else passed++;
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_unknown_error();
    test_inter_timeout();
    test_bus_timeout();
    test_cen();
    test_async_reset();
    total++; if (both_cnt !== 0) $display("FAIL rd_wr_overlap: got %0d cycles expected 0", both_cnt); else passed++;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
